// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: 10 Hz prescaler, BCD minute/second/tenth counters, run/pause/lap/overflow FSM.
// Define STOPWATCH_LAP_EN to build the LAP state and lap-capture registers; default build omits them.
module stopwatch_controller #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] Minutes,
  output logic [3:0] Tens_Seconds,
  output logic [3:0] Ones_Seconds,
  output logic [3:0] Tenths_Seconds,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
  // state | meaning
  // IDLE  | stopped, counters at 0:00.0
  // RUN   | counting, display live
  // LAP   | counting, display frozen on lap registers
  // PAUSE | stopped, counters and prescaler held
  // OVER  | hit 9:59.9, waiting for clear

  localparam int             PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_OVER  = 3'd3
`ifdef STOPWATCH_LAP_EN
    , S_LAP = 3'd4
`endif
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    cnt_min, cnt_tens, cnt_ones, cnt_tenths;
  logic [3:0]    inc_min, inc_tens, inc_ones, inc_tenths;
  logic [3:0]    nx_min, nx_tens, nx_ones, nx_tenths;
  logic          prev_start, prev_clear, ev_start, ev_clear;
  logic          counting, tick, at_max, advance;

`ifdef STOPWATCH_LAP_EN
  logic       prev_lap, ev_lap;
  logic [3:0] lap_min, lap_tens, lap_ones, lap_tenths;
  assign counting = (state == S_RUN) || (state == S_LAP);
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_active = 1'b0;
  assign counting   = (state == S_RUN);
`endif

  assign tick    = counting && (presc == PMAX);
  assign at_max  = (cnt_min == 4'd9) && (cnt_tens == 4'd5) && (cnt_ones == 4'd9) && (cnt_tenths == 4'd9);
  assign advance = tick && !at_max;

  always_comb begin
    inc_min    = cnt_min;
    inc_tens   = cnt_tens;
    inc_ones   = cnt_ones;
    inc_tenths = cnt_tenths + 4'd1;
    if (cnt_tenths == 4'd9) begin
      inc_tenths = '0;
      inc_ones   = cnt_ones + 4'd1;
      if (cnt_ones == 4'd9) begin
        inc_ones = '0;
        inc_tens = cnt_tens + 4'd1;
        if (cnt_tens == 4'd5) begin
          inc_tens = '0;
          inc_min  = cnt_min + 4'd1;
        end
      end
    end
  end

  // Live value after this edge; lap capture uses it so a coincident tick is included.
  assign nx_min    = advance ? inc_min    : cnt_min;
  assign nx_tens   = advance ? inc_tens   : cnt_tens;
  assign nx_ones   = advance ? inc_ones   : cnt_ones;
  assign nx_tenths = advance ? inc_tenths : cnt_tenths;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_start <= 1'b0;
      prev_clear <= 1'b0;
      ev_start   <= 1'b0;
      ev_clear   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      prev_lap   <= 1'b0;
      ev_lap     <= 1'b0;
`endif
    end else begin
      prev_start <= btn_start;
      prev_clear <= btn_clear;
      ev_start   <= btn_start & ~prev_start;
      ev_clear   <= btn_clear & ~prev_clear;
`ifdef STOPWATCH_LAP_EN
      prev_lap   <= btn_lap;
      ev_lap     <= btn_lap & ~prev_lap;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      presc      <= '0;
      cnt_min    <= '0;
      cnt_tens   <= '0;
      cnt_ones   <= '0;
      cnt_tenths <= '0;
      running    <= 1'b0;
      overflow   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_active <= 1'b0;
      lap_min    <= '0;
      lap_tens   <= '0;
      lap_ones   <= '0;
      lap_tenths <= '0;
`endif
    end else begin
      if (counting) presc <= tick ? '0 : presc + PW'(1);
      case (state)
        S_IDLE: begin
          if (ev_clear) begin
            presc      <= '0;
            cnt_min    <= '0;
            cnt_tens   <= '0;
            cnt_ones   <= '0;
            cnt_tenths <= '0;
          end else if (ev_start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick && at_max) begin
            state    <= S_OVER;
            running  <= 1'b0;
            overflow <= 1'b1;
          end else begin
            cnt_min    <= nx_min;
            cnt_tens   <= nx_tens;
            cnt_ones   <= nx_ones;
            cnt_tenths <= nx_tenths;
            if (ev_start) begin
              state   <= S_PAUSE;
              running <= 1'b0;
            end
`ifdef STOPWATCH_LAP_EN
            else if (ev_lap) begin
              state      <= S_LAP;
              lap_active <= 1'b1;
              lap_min    <= nx_min;
              lap_tens   <= nx_tens;
              lap_ones   <= nx_ones;
              lap_tenths <= nx_tenths;
            end
`endif
          end
        end
`ifdef STOPWATCH_LAP_EN
        S_LAP: begin
          if (tick && at_max) begin
            state      <= S_OVER;
            running    <= 1'b0;
            lap_active <= 1'b0;
            overflow   <= 1'b1;
          end else begin
            cnt_min    <= nx_min;
            cnt_tens   <= nx_tens;
            cnt_ones   <= nx_ones;
            cnt_tenths <= nx_tenths;
            if (ev_start) begin
              state      <= S_PAUSE;
              running    <= 1'b0;
              lap_active <= 1'b0;
            end else if (ev_lap) begin
              state      <= S_RUN;
              lap_active <= 1'b0;
            end
          end
        end
`endif
        S_PAUSE: begin
          if (ev_clear) begin
            state      <= S_IDLE;
            presc      <= '0;
            cnt_min    <= '0;
            cnt_tens   <= '0;
            cnt_ones   <= '0;
            cnt_tenths <= '0;
          end else if (ev_start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_OVER: begin
          if (ev_clear) begin
            state      <= S_IDLE;
            overflow   <= 1'b0;
            presc      <= '0;
            cnt_min    <= '0;
            cnt_tens   <= '0;
            cnt_ones   <= '0;
            cnt_tenths <= '0;
`ifdef STOPWATCH_LAP_EN
            lap_min    <= '0;
            lap_tens   <= '0;
            lap_ones   <= '0;
            lap_tenths <= '0;
`endif
          end
        end
        default: begin
          state    <= S_IDLE;
          running  <= 1'b0;
          overflow <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds} = {cnt_min, cnt_tens, cnt_ones, cnt_tenths};
`ifdef STOPWATCH_LAP_EN
    if (state == S_LAP)
      {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds} = {lap_min, lap_tens, lap_ones, lap_tenths};
`endif
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller at TICK_DIV=4; lap scenarios follow STOPWATCH_LAP_EN.
module tb_stopwatch_controller;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
  logic       running, lap_active, overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [18:0] sb[$];
  logic [18:0] got, want;

  stopwatch_controller #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .Minutes(Minutes), .Tens_Seconds(Tens_Seconds),
    .Ones_Seconds(Ones_Seconds), .Tenths_Seconds(Tenths_Seconds),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds, running, lap_active, overflow};
  endfunction

  // t is elapsed tenths; expected digits are derived arithmetically, not by BCD chaining.
  function automatic logic [18:0] mk(input int t, input bit r, input bit l, input bit o);
    logic [3:0] m, ts, os, tn;
    m  = 4'(t / 600);
    ts = 4'((t / 100) % 6);
    os = 4'((t / 10) % 10);
    tn = 4'(t % 10);
    return {m, ts, os, tn, r, l, o};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; returns just after the edge where the FSM acts.
  task automatic press(input bit s, input bit l, input bit c);
    btn_start = s; btn_lap = l; btn_clear = c;
    step(1);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    step(1);
  endtask

  task automatic reset_dut();
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(3);
    sb.push_back(mk(0, 0, 0, 0));
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_hold got=%h want=%h", got, want); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(0, 0, 0, 0));
      step(10);
      want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL idle_no_buttons got=%h want=%h", got, want); end
    end
    btn_start = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    sb.push_back(mk(0, 1, 0, 0));
    step(2);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL held_btn_one_event got=%h want=%h", got, want); end
    sb.push_back(mk(1, 1, 0, 0));
    step(6);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL held_btn_still_run got=%h want=%h", got, want); end
    btn_start = 1'b0;
  endtask

  task automatic test_run();
    reset_dut();
    sb.push_back(mk(0, 1, 0, 0));
    press(1, 0, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL run_entry got=%h want=%h", got, want); end
    sb.push_back(mk(0, 1, 0, 0));
    step(3);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL first_tick_early got=%h want=%h", got, want); end
    sb.push_back(mk(1, 1, 0, 0));
    step(1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL first_tick got=%h want=%h", got, want); end
    sb.push_back(mk(40, 1, 0, 0));
    step(156);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL run_160_cycles got=%h want=%h", got, want); end
  endtask

  task automatic test_lap();
    reset_dut();
    press(1, 0, 0);
    sb.push_back(mk(12, 1, 0, 0));
    step(48);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_pre got=%h want=%h", got, want); end
`ifdef STOPWATCH_LAP_EN
    sb.push_back(mk(12, 1, 1, 0));
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_enter got=%h want=%h", got, want); end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(12, 1, 1, 0));
      step(38);
      want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_frozen got=%h want=%h", got, want); end
    end
    step(2);
    sb.push_back(mk(42, 1, 0, 0));
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_exit_live got=%h want=%h", got, want); end
    step(2);
    sb.push_back(mk(43, 1, 1, 0));
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_on_tick got=%h want=%h", got, want); end
    sb.push_back(mk(43, 0, 0, 0));
    press(1, 0, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_start_pause got=%h want=%h", got, want); end
    sb.push_back(mk(44, 1, 1, 0));
    press(1, 0, 0);
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_after_resume got=%h want=%h", got, want); end
    reset = 1'b0;
    #2;
    sb.push_back(mk(0, 0, 0, 0));
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_in_lap got=%h want=%h", got, want); end
    step(1);
    reset = 1'b1;
    step(1);
`else
    sb.push_back(mk(12, 1, 0, 0));
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_ignored got=%h want=%h", got, want); end
    sb.push_back(mk(14, 1, 0, 0));
    step(6);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL lap_ignored_run got=%h want=%h", got, want); end
`endif
  endtask

  task automatic test_pause_clear();
    reset_dut();
    press(1, 0, 0);
    sb.push_back(mk(7, 1, 0, 0));
    step(28);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pre_pause got=%h want=%h", got, want); end
    sb.push_back(mk(7, 0, 0, 0));
    press(1, 0, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pause_enter got=%h want=%h", got, want); end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(7, 0, 0, 0));
      step(25);
      want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pause_hold got=%h want=%h", got, want); end
    end
    // prescaler was left at 2 of 0..3, so the next tick is two cycles after resume
    sb.push_back(mk(7, 1, 0, 0));
    press(1, 0, 0);
    step(1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL resume_subtick got=%h want=%h", got, want); end
    sb.push_back(mk(8, 1, 0, 0));
    step(1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL resume_tick got=%h want=%h", got, want); end
    sb.push_back(mk(8, 0, 0, 0));
    press(1, 0, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pause_again got=%h want=%h", got, want); end
    sb.push_back(mk(0, 0, 0, 0));
    press(0, 0, 1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pause_clear got=%h want=%h", got, want); end
    press(1, 0, 0);
    sb.push_back(mk(0, 1, 0, 0));
    step(3);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL clear_zeroed_presc got=%h want=%h", got, want); end
    sb.push_back(mk(1, 1, 0, 0));
    step(1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL clear_first_tick got=%h want=%h", got, want); end
    sb.push_back(mk(1, 1, 0, 0));
    press(0, 0, 1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL clear_in_run got=%h want=%h", got, want); end
    sb.push_back(mk(2, 1, 0, 0));
    step(2);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL clear_in_run_counting got=%h want=%h", got, want); end
  endtask

  task automatic test_overflow();
    int waits[5] = '{396, 4, 1996, 4, 21596};
    int ticks[5] = '{99, 100, 599, 600, 5999};
    reset_dut();
    press(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(ticks[i], 1, 0, 0));
      step(waits[i]);
      want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL carry_chain got=%h want=%h", got, want); end
    end
    sb.push_back(mk(5999, 1, 0, 0));
    step(3);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL max_before_tick got=%h want=%h", got, want); end
    sb.push_back(mk(5999, 0, 0, 1));
    step(1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL overflow_enter got=%h want=%h", got, want); end
    sb.push_back(mk(5999, 0, 0, 1));
    step(20);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL overflow_hold got=%h want=%h", got, want); end
    sb.push_back(mk(5999, 0, 0, 1));
    press(1, 0, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL over_start_ignored got=%h want=%h", got, want); end
    sb.push_back(mk(5999, 0, 0, 1));
    press(0, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL over_lap_ignored got=%h want=%h", got, want); end
    sb.push_back(mk(0, 0, 0, 0));
    press(0, 0, 1);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL over_clear got=%h want=%h", got, want); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    press(1, 0, 0);
    sb.push_back(mk(2, 1, 0, 0));
    step(10);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL b2b_pre got=%h want=%h", got, want); end
    // start wins over lap, and the tick on the same edge still lands
    sb.push_back(mk(3, 0, 0, 0));
    press(1, 1, 0);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL start_lap_same_cycle got=%h want=%h", got, want); end
    reset_dut();
    press(1, 0, 0);
    sb.push_back(mk(23, 1, 0, 0));
    step(94);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL pre_reset got=%h want=%h", got, want); end
    reset = 1'b0;
    #2;
    sb.push_back(mk(0, 0, 0, 0));
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL reset_async got=%h want=%h", got, want); end
    step(2);
    reset = 1'b1;
    sb.push_back(mk(0, 0, 0, 0));
    step(20);
    want = sb.pop_front(); got = obs(); n_cmp++; if (got !== want) begin n_err++; $display("FAIL idle_after_reset got=%h want=%h", got, want); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_lap();
    test_pause_clear();
    test_overflow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
